// File: rtl/iod_dly_tap_seq.sv
// iod_dly_tap_seq: delay-line tap sequencer for the DDR3 command/address IOD lanes.
// Accepts one move/load request at a time and drives the selected lane's DIRECTION,
// MOVE and LOAD with setup and settle spacing. It samples OUT_OF_RANGE once at the end
// of every settle gap and reports completion status.
//
// Ports:
//   fab_clk_i, arst_ni        fabric clock, async active-low reset
//   req_*_i / req_ready_o     request handshake (lane, load/move, dir, count)
//   done_o, done_status_o     completion pulse; status 00 ok, 01 out-of-range, 10 bad lane
//   done_moves_o              MOVE pulses issued for the last request
//   dl_move_o, dl_dir_o,
//   dl_load_o, dl_oor_i       per-lane IOD delay-line controls / range flag
//   rd_lane_i, rd_tap_o       registered tap readback (1-cycle latency)
//
// Build option: define IOD_DLY_TAP_SEQ_TRACK_EN to keep per-lane tap positions and
// enable the readback. When it is undefined, rd_tap_o is constant 0.
module iod_dly_tap_seq #(
  parameter int unsigned NUM_LANES  = 8,
  parameter int unsigned TAP_W      = 8,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TAP_INIT   = 1,
  localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 fab_clk_i,
  input  logic                 arst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [LW-1:0]        req_lane_i,
  input  logic                 req_load_i,
  input  logic                 req_dir_i,
  input  logic [TAP_W-1:0]     req_count_i,
  output logic                 done_o,
  output logic [1:0]           done_status_o,
  output logic [TAP_W-1:0]     done_moves_o,
  output logic [NUM_LANES-1:0] dl_move_o,
  output logic [NUM_LANES-1:0] dl_dir_o,
  output logic [NUM_LANES-1:0] dl_load_o,
  input  logic [NUM_LANES-1:0] dl_oor_i,
  input  logic [LW-1:0]        rd_lane_i,
  output logic [TAP_W-1:0]     rd_tap_o
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StGap, StFin} state_e;

  state_e                 state_q, state_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic                   load_q, load_d;
  logic                   dir_q, dir_d;
  logic [TAP_W-1:0]       count_q, count_d;
  logic [TAP_W-1:0]       moves_q, moves_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [1:0]             status_q, status_d;
  logic [TAP_W-1:0]       dmoves_q, dmoves_d;
  logic [NUM_LANES-1:0]   line_dir_q, line_dir_d;
  logic                   lane_ok;

  assign lane_ok = 32'(lane_q) < NUM_LANES;

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    load_d      = load_q;
    dir_d       = dir_q;
    count_d     = count_q;
    moves_d     = moves_q;
    gap_d       = gap_q;
    status_d    = status_q;
    dmoves_d    = dmoves_q;
    line_dir_d  = line_dir_q;
    req_ready_o = 1'b0;
    done_o      = 1'b0;
    dl_move_o   = '0;
    dl_load_o   = '0;
    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          lane_d  = req_lane_i;
          load_d  = req_load_i;
          dir_d   = req_dir_i;
          count_d = req_count_i;
          moves_d = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (!lane_ok) begin
          status_d = 2'b10;
          dmoves_d = moves_q;
          state_d  = StFin;
        end else if (!load_q && (count_q == '0)) begin
          status_d = 2'b00;
          dmoves_d = moves_q;
          state_d  = StFin;
        end else begin
          if (!load_q) line_dir_d[lane_q] = dir_q;
          state_d = StPulse;
        end
      end
      StPulse: begin
        if (load_q) begin
          dl_load_o[lane_q] = 1'b1;
        end else begin
          dl_move_o[lane_q] = 1'b1;
          moves_d = moves_q + 1'b1;
        end
        gap_d   = GW'(GAP_CYCLES - 1);
        state_d = StGap;
      end
      StGap: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (dl_oor_i[lane_q]) begin
          status_d = 2'b01;
          dmoves_d = moves_q;
          state_d  = StFin;
        end else if (load_q || (moves_q == count_q)) begin
          status_d = 2'b00;
          dmoves_d = moves_q;
          state_d  = StFin;
        end else begin
          state_d = StPulse;
        end
      end
      StFin: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Taking the next-state value lets the new direction show during the SETUP cycle,
  // one cycle ahead of the first MOVE.
  assign dl_dir_o      = line_dir_d;
  assign done_status_o = status_q;
  assign done_moves_o  = dmoves_q;

  always_ff @(posedge fab_clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= StIdle;
      lane_q     <= '0;
      load_q     <= 1'b0;
      dir_q      <= 1'b0;
      count_q    <= '0;
      moves_q    <= '0;
      gap_q      <= '0;
      status_q   <= 2'b00;
      dmoves_q   <= '0;
      line_dir_q <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      load_q     <= load_d;
      dir_q      <= dir_d;
      count_q    <= count_d;
      moves_q    <= moves_d;
      gap_q      <= gap_d;
      status_q   <= status_d;
      dmoves_q   <= dmoves_d;
      line_dir_q <= line_dir_d;
    end
  end

`ifdef IOD_DLY_TAP_SEQ_TRACK_EN
  logic [TAP_W-1:0] tap_q [NUM_LANES];
  logic [TAP_W-1:0] rd_tap_q;

  // Positions saturate at both ends; only OUT_OF_RANGE ends a sequence.
  always_ff @(posedge fab_clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < int'(NUM_LANES); i++) tap_q[i] <= TAP_W'(TAP_INIT);
      rd_tap_q <= '0;
    end else begin
      if (state_q == StPulse) begin
        if (load_q) begin
          tap_q[lane_q] <= TAP_W'(TAP_INIT);
        end else if (dir_q && (tap_q[lane_q] != '1)) begin
          tap_q[lane_q] <= tap_q[lane_q] + 1'b1;
        end else if (!dir_q && (tap_q[lane_q] != '0)) begin
          tap_q[lane_q] <= tap_q[lane_q] - 1'b1;
        end
      end
      rd_tap_q <= (32'(rd_lane_i) < NUM_LANES) ? tap_q[rd_lane_i] : '0;
    end
  end

  assign rd_tap_o = rd_tap_q;
`else
  logic             unused_rd_lane;
  logic [TAP_W-1:0] unused_tap_init;
  assign unused_rd_lane  = ^rd_lane_i;
  assign unused_tap_init = TAP_W'(TAP_INIT);
  assign rd_tap_o        = '0;
`endif

endmodule

// File: doc/iod_dly_tap_seq.md
# iod_dly_tap_seq

Delay-line tap sequencer for the DDR3 command/address IOD lanes (CAS_N, RAS_N, WE_N, ...), each configured with dynamic delay-line enable. It accepts one tap-adjust or load request at a time from the training/calibration logic and drives that lane's DELAY_LINE_DIRECTION, DELAY_LINE_MOVE and DELAY_LINE_LOAD with correct setup and settle spacing. It monitors DELAY_LINE_OUT_OF_RANGE, tracks tap position per lane, and reports completion status.

## Interface
Parameters:
- NUM_LANES, 8, number of IOD lanes served (lane index width LW = clog2(NUM_LANES), min 1)
- TAP_W, 8, tap counter / request count width
- GAP_CYCLES, 4, settle cycles after every MOVE/LOAD pulse (≥1)
- TAP_INIT, 1, tap position after LOAD or reset (matches TX_DELAY_VAL)

Ports:
- FAB_CLK  in  1  fabric clock; all logic on rising edge
- ARST_N  in  1  reset, asynchronous, active-low
- REQ_VALID  in  1  request present
- REQ_READY  out  1  block idle, request accepted when VALID&READY
- REQ_LANE  in  LW  target lane
- REQ_LOAD  in  1  1 = load (reset delay), 0 = move
- REQ_DIR  in  1  move direction, 1 = increase delay
- REQ_COUNT  in  TAP_W  taps to move (ignored for load)
- DONE  out  1  one-cycle completion pulse
- DONE_STATUS  out  2  00 OK, 01 OUT_OF_RANGE, 10 BAD_LANE; held until next DONE
- DONE_MOVES  out  TAP_W  MOVE pulses issued for the request; held until next DONE
- DELAY_LINE_MOVE  out  NUM_LANES  per-lane move pulse
- DELAY_LINE_DIRECTION  out  NUM_LANES  per-lane direction, held between requests
- DELAY_LINE_LOAD  out  NUM_LANES  per-lane load pulse
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane IOD range flag
- RD_LANE  in  LW  tap readback select
- RD_TAP  out  TAP_W  registered tap position of RD_LANE, 1-cycle latency

## Operation
- States: IDLE, SETUP, PULSE, GAP, FIN.
- IDLE: REQ_READY=1. On accept, latch lane/load/dir/count, clear move counter, go SETUP.
- SETUP (1 cycle): if lane ≥ NUM_LANES → FIN, status 10. If move with COUNT=0 → FIN, status 00. Else drive DIRECTION[lane]=dir (moves only) → PULSE.
- PULSE (1 cycle): MOVE[lane]=1 (or LOAD[lane]=1 for load); only the selected bit is ever high. Moves increment move counter. → GAP.
- GAP (GAP_CYCLES cycles): all MOVE/LOAD low. On last GAP cycle sample OUT_OF_RANGE[lane]: if 1 → FIN status 01; else if load, or moves == COUNT → FIN status 00; else → PULSE (DIRECTION unchanged).
- FIN (1 cycle): DONE=1, DONE_STATUS/DONE_MOVES updated; → IDLE.
- Tap tracking: move with dir=1 adds 1, dir=0 subtracts 1, saturating at 0 and 2^TAP_W−1; load sets TAP_INIT; updated in PULSE cycle. Saturation at a bound does not stop sequencing; only OUT_OF_RANGE does.
- REQ_* are ignored outside IDLE; request fields are don't-care after accept.

## Timing
- Reset (async, ARST_N low): state IDLE, REQ_READY=1, DONE=0, DONE_STATUS=00, DONE_MOVES=0, all MOVE/LOAD/DIRECTION=0, RD_TAP=0, all tap positions=TAP_INIT. Reset mid-sequence aborts immediately; no further pulses, no DONE.
- Accept at cycle 0 (G=GAP_CYCLES): pulse k (0-based) at cycle 2+k·(G+1); DONE at 2+N·(G+1); REQ_READY high again the following cycle. Back-to-back accept possible on that cycle.
- OUT_OF_RANGE checked only at cycle 1+(k+1)·(G+1); asserted elsewhere it is ignored.
- Load: LOAD pulse cycle 2, DONE cycle 3+G. Bad lane or COUNT=0: DONE cycle 2, no pulses.
- DIRECTION changes only in SETUP, ≥1 cycle before the first MOVE.

## Configuration
- IOD_DLY_TAP_SEQ_TRACK_EN defined: per-lane tap position registers and RD_LANE/RD_TAP readback as above.
- Not defined: no tap registers; RD_TAP constant 0; all sequencing, status and DONE_MOVES unchanged.

## Test plan
- Reset release, GAP_CYCLES=4: lane 2, move dir=1, COUNT=3 → MOVE[2] high at cycles 2,7,12 only, DONE cycle 17, status 00, DONE_MOVES=3, RD_TAP(lane 2)=4.
- Lane 5 move dir=0 COUNT=10, OUT_OF_RANGE[5] high at cycle 11 → pulses at 2 and 7 only, DONE cycle 12, status 01, DONE_MOVES=2.
- Lane 1 load after moves → LOAD[1] high cycle 2 only, DONE cycle 7, status 00, RD_TAP=1; no MOVE activity.
- NUM_LANES=6, REQ_LANE=7 → DONE cycle 2, status 10, no pulses; COUNT=0 on lane 0 → DONE cycle 2, status 00, DONE_MOVES=0.
- REQ_VALID held high during busy with changed fields → second request accepted only on the cycle after DONE, first request unaffected.
- ARST_N low at cycle 8 of a 5-tap move → all outputs reset values immediately, no DONE, REQ_READY=1, taps=TAP_INIT; new request after release runs normally.
